// File: rtl/muldiv_unit.sv
//==============================================================================
// Module   : muldiv_unit
// Brief    : Iterative 32-cycle multiply/divide unit feeding the HI/LO registers.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] data_in1,
    input  logic [WIDTH-1:0] data_in2,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int                 c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_is_div;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic               r_dbz;
    logic               r_busy;
    logic               r_done;
    logic               r_dbz_pulse;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    // Operand magnitudes and sign bookkeeping for the signed ops
    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;

    assign w_signed = ~op[0];
    assign w_a_neg  = w_signed & data_in1[WIDTH-1];
    assign w_b_neg  = w_signed & data_in2[WIDTH-1];
    assign w_mag_a  = w_a_neg ? -data_in1 : data_in1;
    assign w_mag_b  = w_b_neg ? -data_in2 : data_in2;

    // Shift-add step: accumulator upper half gains the multiplicand, then shifts right
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;

    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_b[0] ? {1'b0, r_a} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring step: upper half is the partial remainder, lower half collects quotient bits
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_diff;
    logic               w_q_bit;
    logic [WIDTH-1:0]   w_rem_next;
    logic [2*WIDTH-1:0] w_div_next;

    assign w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_a[WIDTH-1]};
    assign w_diff     = w_rem_sh - {1'b0, r_b};
    assign w_q_bit    = ~w_diff[WIDTH];
    assign w_rem_next = w_q_bit ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    assign w_div_next = {w_rem_next, r_acc[WIDTH-2:0], w_q_bit};

    // Final sign correction; a zero divisor leaves |dividend| as remainder, which
    // the dividend-sign fix-up turns back into the original dividend
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;

    assign w_prod = r_neg_res ? -r_acc : r_acc;
    assign w_quot = r_dbz ? '1 : (r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
    assign w_rem  = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = S_CALC;
            S_CALC:  if (r_cnt == c_LAST) w_next_state = S_FIX;
            S_FIX:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_acc       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_is_div    <= 1'b0;
            r_neg_res   <= 1'b0;
            r_neg_rem   <= 1'b0;
            r_dbz       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_dbz_pulse <= 1'b0;
            r_hi        <= '0;
            r_lo        <= '0;
        end else begin
            r_done      <= 1'b0;
            r_dbz_pulse <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (hi_we) r_hi <= wdata;
                    if (lo_we) r_lo <= wdata;
                    if (start) begin
                        r_busy    <= 1'b1;
                        r_is_div  <= op[1];
                        r_a       <= w_mag_a;
                        r_b       <= w_mag_b;
                        r_neg_res <= w_a_neg ^ w_b_neg;
                        r_neg_rem <= w_a_neg;
                        r_dbz     <= op[1] & (data_in2 == '0);
                        r_acc     <= '0;
                        r_cnt     <= '0;
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                    if (r_is_div) begin
                        r_acc <= w_div_next;
                        r_a   <= r_a << 1;
                    end else begin
                        r_acc <= w_mul_next;
                        r_b   <= r_b >> 1;
                    end
                end
                S_FIX: begin
                    if (r_is_div) begin
                        r_hi <= w_rem;
                        r_lo <= w_quot;
                    end else begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end
                    r_done      <= 1'b1;
                    r_dbz_pulse <= r_dbz;
                    r_busy      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign div_by_zero = r_dbz_pulse;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
//==============================================================================
// Module   : tb_muldiv_unit
// Brief    : Scoreboard bench for muldiv_unit against an arithmetic reference.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] data_in1;
    logic [31:0] data_in2;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .data_in1    (data_in1),
        .data_in2    (data_in2),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          cyc;
    } exp_t;

    exp_t scb[$];
    int   total = 0;
    int   bad   = 0;
    logic [31:0] last_hi;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [31:0] a,
                                   input logic [31:0] b, input int c);
        exp_t e;
        longint sa, sbv, p, q, r;
        longint unsigned ua, ub, up, uq, ur;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        e.dbz = 1'b0;
        e.cyc = c;
        e.hi  = '0;
        e.lo  = '0;
        case (o)
            2'd0: begin p = sa * sbv; e.hi = p[63:32]; e.lo = p[31:0]; end
            2'd1: begin up = ua * ub; e.hi = up[63:32]; e.lo = up[31:0]; end
            default: begin
                if (b == 32'd0) begin
                    e.hi = a; e.lo = 32'hFFFF_FFFF; e.dbz = 1'b1;
                end else if (o == 2'd2) begin
                    q = sa / sbv; r = sa % sbv; e.lo = q[31:0]; e.hi = r[31:0];
                end else begin
                    uq = ua / ub; ur = ua % ub; e.lo = uq[31:0]; e.hi = ur[31:0];
                end
            end
        endcase
        return e;
    endfunction

    // Monitor: pops the scoreboard whenever a result is presented
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n === 1'b1) begin
            if (done === 1'b1) begin
                if (scb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_done: got done=1 want no result pending");
                end else begin
                    e = scb.pop_front();
                    chk("hi", hi, e.hi);
                    chk("lo", lo, e.lo);
                    chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.dbz});
                    chk("latency_cycle", cyc, e.cyc);
                    chk("busy_in_done", {31'b0, busy}, 32'd0);
                    last_hi = e.hi;
                end
            end else begin
                chk("dbz_outside_done", {31'b0, div_by_zero}, 32'd0);
            end
        end
    end

    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        @(negedge clk);
        while (busy && n < 200) begin @(negedge clk); n++; end
        if (busy) begin
            total++; bad++;
            $display("FAIL idle_wait: got busy=1 want 0 within 200 cycles");
        end
        op = o; data_in1 = a; data_in2 = b; start = 1'b1;
        scb.push_back(model(o, a, b, cyc + 34));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (scb.size() > 0 && n < 200) begin @(negedge clk); n++; end
        if (scb.size() > 0) begin
            total++; bad++;
            $display("FAIL drain_timeout: got pending=%0d want 0", scb.size());
            scb.delete();
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        rst_n = 1'b0; start = 1'b0; op = 2'd0; data_in1 = '0; data_in2 = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0; last_hi = '0;
        repeat (3) @(negedge clk);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_dbz", {31'b0, div_by_zero}, 32'd0);
        rst_n = 1'b1;

        do_op(2'd0, 32'hFFFF_FFFF, 32'h0000_0002);
        do_op(2'd1, 32'hFFFF_FFFF, 32'h0000_0002);
        do_op(2'd2, 32'hFFFF_FFF9, 32'h0000_0002);
        do_op(2'd3, 32'd100, 32'd7);
        do_op(2'd3, 32'h1234_5678, 32'h0000_0000);
        do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op(2'd2, 32'h8000_0000, 32'h0000_0000);
        drain();

        // Mid-operation start and MTHI must both be ignored
        do_op(2'd0, 32'h0001_2345, 32'hFFFF_F777);
        repeat (5) @(negedge clk);
        op = 2'd3; data_in1 = 32'd1; data_in2 = 32'd0; start = 1'b1;
        hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("busy_mid_calc", {31'b0, busy}, 32'd1);
        start = 1'b0; hi_we = 1'b0;
        drain();
        @(negedge clk);
        lo_we = 1'b1; wdata = 32'hCAFE_F00D;
        @(negedge clk);
        lo_we = 1'b0;
        chk("mtlo_lo", lo, 32'hCAFE_F00D);
        chk("mtlo_hi_kept", hi, last_hi);

        // Reset in the middle of an operation discards it
        do_op(2'd0, 32'h0000_1111, 32'h0000_2222);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        scb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        do_op(2'd1, 32'd3, 32'd5);
        drain();

        for (int i = 0; i < 40; i++) begin
            do_op(2'($urandom_range(0, 3)), pick(), pick());
        end
        drain();
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
